// File: rtl/pcap_replay_axis_deframer.sv
// pcap record deframer: pops 64-bit FWFT words, strips record headers and emits payload as AXI-Stream.
// Optional statistics counters are enabled with `define PCAP_REPLAY_STATS_EN.
module pcap_replay_axis_deframer #(
  parameter int         C_M_AXIS_DATA_WIDTH  = 64,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter int         MAX_PKT_LEN          = 9600,
  parameter logic [7:0] SRC_PORT             = 8'h01,
  parameter logic [7:0] DST_PORT             = 8'h00
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic [63:0]                     fifo_dout,
  input  logic                            fifo_empty,
  output logic                            fifo_rd_en,
  input  logic                            replay_en,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [7:0]                      m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [15:0]                     drop_count,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     byte_count
);

  // state | meaning
  // IDLE  | between records, waits for replay_en
  // HDR0  | pops timestamp word
  // HDR1  | pops length word, classifies record
  // DATA  | streams payload words
  // DROP  | discards payload of an oversize record
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DROP} state_t;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_PKT_LEN);

  state_t      state;
  logic [63:0] ts;
  logic [15:0] incl_len;
  logic [12:0] words_left;

  logic [15:0]  hdr_len;
  logic [12:0]  hdr_words_m1;
  logic         hdr_zero, hdr_over;
  logic         in_data, last_word, beat;
  logic [15:0]  drop_inc;
  logic [127:0] tuser_full;

  assign hdr_len      = fifo_dout[15:0];
  // Loaded as word count minus one so a full 64 KiB record still fits 13 bits.
  assign hdr_words_m1 = 13'((hdr_len - 16'd1) >> 3);
  assign hdr_zero     = (fifo_dout[31:0] == 32'h0);
  assign hdr_over     = (|fifo_dout[31:16]) || (hdr_len > MAX_LEN16);
  assign drop_inc     = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;

  assign in_data   = (state == DATA);
  assign last_word = (words_left == 13'd0);
  assign beat      = m_axis_tvalid & m_axis_tready;

  assign fifo_rd_en    = !fifo_empty && ((state == HDR0) || (state == HDR1) || (state == DROP) ||
                                         (in_data && m_axis_tready));
  assign m_axis_tvalid = in_data && !fifo_empty;
  assign m_axis_tdata  = fifo_dout;
  assign m_axis_tlast  = in_data && last_word;
  assign m_axis_tkeep  = !in_data ? 8'h00 :
                         (last_word && (incl_len[2:0] != 3'd0)) ?
                           (8'hFF >> (4'd8 - {1'b0, incl_len[2:0]})) : 8'hFF;
  assign tuser_full    = in_data ? {32'h0, ts, DST_PORT, SRC_PORT, incl_len} : 128'h0;
  assign m_axis_tuser  = tuser_full[C_M_AXIS_TUSER_WIDTH-1:0];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= IDLE;
      ts         <= '0;
      incl_len   <= '0;
      words_left <= '0;
      drop_count <= '0;
    end else begin
      unique case (state)
        IDLE: if (replay_en) state <= HDR0;
        HDR0: if (!fifo_empty) begin
          ts    <= fifo_dout;
          state <= HDR1;
        end
        HDR1: if (!fifo_empty) begin
          incl_len   <= hdr_len;
          words_left <= hdr_words_m1;
          if (hdr_zero) begin
            drop_count <= drop_inc;
            state      <= IDLE;
          end else if (hdr_over) begin
            drop_count <= drop_inc;
            state      <= (hdr_len == 16'd0) ? IDLE : DROP;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (beat) begin
          if (last_word) state <= IDLE;
          else           words_left <= words_left - 13'd1;
        end
        DROP: if (!fifo_empty) begin
          if (last_word) state <= IDLE;
          else           words_left <= words_left - 13'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PCAP_REPLAY_STATS_EN
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else if (beat && m_axis_tlast) begin
      pkt_count  <= pkt_count + 32'd1;
      byte_count <= byte_count + {16'h0, incl_len};
    end
  end
`else
  assign pkt_count  = 32'h0;
  assign byte_count = 32'h0;
`endif

endmodule

// File: tb/tb_pcap_replay_axis_deframer.sv
// Self-checking bench: a queue models the FWFT FIFO, a scoreboard holds the expected output beats.
module tb_pcap_replay_axis_deframer;
  logic          axi_aclk = 1'b0;
  logic          axi_aresetn;
  logic [63:0]   fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          replay_en;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [15:0]   drop_count;
  logic [31:0]   pkt_count;
  logic [31:0]   byte_count;

  typedef struct packed {
    logic [63:0]  d;
    logic [7:0]   k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] fq[$];
  int          errors = 0;
  int          checks = 0;
  int          pops   = 0;
  bit          gap_mode = 0;
  bit          toggle_mode = 0;
  bit          stall_prev = 0;
  beat_t       held;

  pcap_replay_axis_deframer dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .replay_en(replay_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .drop_count(drop_count), .pkt_count(pkt_count), .byte_count(byte_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge axi_aclk) begin
    beat_t obs, e;
    obs = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    if (axi_aresetn) begin
      checks++;
      assert (!(fifo_rd_en && fifo_empty)) else begin
        errors++;
        $error("FAIL rd_en_while_empty observed=1 expected=0");
      end
      if (stall_prev && m_axis_tvalid) begin
        checks++;
        assert (obs === held) else begin
          errors++;
          $error("FAIL stall_stable observed=%h expected=%h", obs, held);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=%h expected=none", obs);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert (obs === e) else begin
            errors++;
            $error("FAIL beat observed=%h expected=%h", obs, e);
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = obs;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit p;
    @(posedge axi_aclk);
    p = fifo_rd_en;
    #1;
    if (p && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    fifo_empty = (fq.size() == 0) || (gap_mode && ($urandom_range(0, 2) == 0));
    fifo_dout  = (fq.size() > 0) ? fq[0] : 64'h0;
    if (toggle_mode) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic push_record(input logic [31:0] sec, input logic [31:0] usec,
                             input logic [31:0] len, input bit emit);
    int          nw, r;
    logic [63:0] w;
    logic [7:0]  k;
    nw = (int'(len[15:0]) + 7) / 8;
    r  = int'(len[2:0]);
    fq.push_back({usec, sec});
    fq.push_back({len, len});
    for (int i = 0; i < nw; i++) begin
      w = {$urandom, $urandom};
      fq.push_back(w);
      k = (i == nw - 1 && r != 0) ? 8'((1 << r) - 1) : 8'hFF;
      if (emit) sb.push_back({w, k, (i == nw - 1), {32'h0, usec, sec, 8'h00, 8'h01, len[15:0]}});
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fq.size() > 0 || sb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", (n < budget), 1);
    repeat (3) step();
  endtask

  task automatic wait_sb(input int target, input int budget);
    int n = 0;
    while (sb.size() > target && n < budget) begin
      step();
      n++;
    end
    chk("wait_timeout", (n < budget), 1);
  endtask

  task automatic check_stats(input logic [31:0] p, input logic [31:0] b);
`ifdef PCAP_REPLAY_STATS_EN
    chk("pkt_count", pkt_count, p);
    chk("byte_count", byte_count, b);
`else
    chk("pkt_count", pkt_count, 0);
    chk("byte_count", byte_count, 0);
    if (p == 32'hFFFF_FFFF) chk("stats_arg", b, b + 0);
`endif
  endtask

  task automatic check_reset_outputs();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_drop_count", drop_count, 0);
    check_stats(0, 0);
  endtask

  initial begin
    int p0;
    axi_aresetn = 1'b0;
    replay_en = 1'b0;
    m_axis_tready = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout = 64'h0;
    repeat (3) step();
    check_reset_outputs();
    axi_aresetn = 1'b1;
    step();

    // basic 64-byte record
    replay_en = 1'b1;
    push_record(32'd1, 32'd2, 32'd64, 1);
    drain(200);
    chk("drop_after_t1", drop_count, 0);
    check_stats(1, 64);

    // partial last words, back to back
    push_record(32'h11, 32'h22, 32'd61, 1);
    push_record(32'h33, 32'h44, 32'd60, 1);
    drain(200);
    check_stats(3, 185);

    // oversize record is discarded, following record intact
    p0 = pops;
    push_record(32'h55, 32'h66, 32'd10000, 0);
    push_record(32'h77, 32'h88, 32'd64, 1);
    drain(3000);
    chk("drop_pops", pops - p0, 1262);
    chk("drop_after_oversize", drop_count, 1);
    check_stats(4, 249);

    // zero-length record then single-word record
    push_record(32'h99, 32'hAA, 32'd0, 0);
    push_record(32'hBB, 32'hCC, 32'd8, 1);
    drain(200);
    chk("drop_after_zero", drop_count, 2);
    check_stats(5, 257);

    // backpressure and FIFO bubbles
    gap_mode = 1;
    toggle_mode = 1;
    push_record(32'h101, 32'h202, 32'd64, 1);
    push_record(32'h303, 32'h404, 32'd61, 1);
    push_record(32'h505, 32'h606, 32'd13, 1);
    drain(2000);
    gap_mode = 0;
    toggle_mode = 0;
    m_axis_tready = 1'b1;
    step();
    check_stats(8, 395);

    // replay_en dropped mid-packet: current record finishes, next one waits
    push_record(32'h1001, 32'h2002, 32'd64, 1);
    push_record(32'h3003, 32'h4004, 32'd64, 1);
    wait_sb(12, 100);
    replay_en = 1'b0;
    wait_sb(8, 100);
    repeat (10) step();
    chk("hold_fifo_level", fq.size(), 10);
    chk("hold_sb_level", sb.size(), 8);
    check_stats(9, 459);

    // reset mid-packet
    replay_en = 1'b1;
    wait_sb(5, 100);
    axi_aresetn = 1'b0;
    replay_en = 1'b0;
    fq.delete();
    sb.delete();
    fifo_empty = 1'b1;
    fifo_dout = 64'h0;
    #2;
    check_reset_outputs();
    step();
    axi_aresetn = 1'b1;
    push_record(32'h5005, 32'h6006, 32'd64, 1);
    repeat (6) step();
    chk("idle_after_reset", fq.size(), 10);
    chk("idle_tvalid", m_axis_tvalid, 0);
    replay_en = 1'b1;
    drain(200);
    check_stats(1, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
